isr_imem_loadable: RTL

Parametrised, run-time loadable instruction store for the exception/interrupt service routine region.
- Fetch side: same interface as the fixed ISR ROM. Registered word address, combinational word output.
- Contents are written by a handshake loader (boot loader / debug UART path), not fixed at synthesis.
- Adds stall-hold of the fetch address, out-of-range NOP return, and fetch blanking while a load is in progress.

---
 rtl/isr_imem_loadable_pkg.sv | 15 +
 rtl/isr_imem_loader.sv | 124 ++++++++++++
 rtl/isr_imem_loadable.sv | 86 ++++++++
 3 files changed

// File: rtl/isr_imem_loadable_pkg.sv
// Shared definitions for the loadable ISR instruction store: loader FSM
// state encoding and the default word returned for blanked fetches.
package isr_imem_loadable_pkg;

    // Loader FSM states; the fetch stage only reads contents in ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    // Word presented on the fetch port when no valid content is available.
    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

endpackage : isr_imem_loadable_pkg

// File: rtl/isr_imem_loader.sv
// Handshake loader for the ISR instruction store. Accepts a base index and
// a word count, then streams words into consecutive indices (wrapping at
// DEPTH). Reports completion with a single-cycle ld_done pulse and raises
// loaded once a full load has finished without an abort.
module isr_imem_loader
    import isr_imem_loadable_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [IDX_W-1:0]  ld_base,
    input  logic [IDX_W:0]    ld_len,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_abort,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              we,
    output logic [IDX_W-1:0]  waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              loaded
);

    // DEPTH is a power of two, so it fits exactly in the IDX_W+1 bit counter.
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0] CNT_ONE   = (IDX_W + 1)'(1);

    ld_state_e        state;
    ld_state_e        state_nxt;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] wr_ptr_nxt;
    logic [IDX_W:0]   cnt;
    logic [IDX_W:0]   cnt_nxt;
    logic             loaded_nxt;

    // Requests longer than the array would only overwrite words already
    // written in this load, so they are clamped to one full pass.
    function automatic logic [IDX_W:0] clamp_len(input logic [IDX_W:0] len);
        return (len > DEPTH_CNT) ? DEPTH_CNT : len;
    endfunction

    // State, write pointer, remaining count and loaded flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            cnt    <= '0;
            loaded <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            cnt    <= cnt_nxt;
            loaded <= loaded_nxt;
        end
    end

    // Next-state decode and handshake outputs; abort overrides completion.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        cnt_nxt    = cnt;
        loaded_nxt = loaded;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        we         = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (ld_start) begin
                    if (ld_len == '0) begin
                        // Empty load completes at once and re-validates contents.
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt  = ST_LOAD;
                        wr_ptr_nxt = ld_base;
                        cnt_nxt    = clamp_len(ld_len);
                        loaded_nxt = 1'b0;
                    end
                end
            end

            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    // A beat offered alongside an abort is still committed.
                    we         = 1'b1;
                    wr_ptr_nxt = wr_ptr + IDX_W'(1);
                    cnt_nxt    = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = ST_DONE;
                    end
                end
                if (ld_abort) begin
                    state_nxt  = ST_IDLE;
                    loaded_nxt = 1'b0;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
                if (ld_abort) begin
                    loaded_nxt = 1'b0;
                end else begin
                    ld_done    = 1'b1;
                    loaded_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ld_busy = (state != ST_IDLE);
    assign waddr   = wr_ptr;
    assign wdata   = ld_data;

endmodule : isr_imem_loader

// File: rtl/isr_imem_loadable.sv
// Run-time loadable ISR instruction store. Fetch side mirrors the fixed
// ISR ROM: registered word address, combinational instruction output.
// Contents come from the handshake loader; fetches are blanked to NOP while
// a load is running, before any complete load, or when out of range.
module isr_imem_loadable
    import isr_imem_loadable_pkg::*;
#(
    parameter int                DEPTH    = 64,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 30,
    parameter int                IDX_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stall,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              ld_start,
    input  logic [IDX_W-1:0]  ld_base,
    input  logic [IDX_W:0]    ld_len,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_abort,
    output logic              ld_busy,
    output logic              ld_done
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_p0;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic              loaded;
    logic              in_range;
    logic              fetch_ok;

    isr_imem_loader #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_loader (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_abort (ld_abort),
        .ld_busy  (ld_busy),
        .ld_done  (ld_done),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .loaded   (loaded)
    );

    // Stage p0: fetch address register, held while the core stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_p0 <= '0;
        end else if (!stall) begin
            addr_p0 <= addr;
        end
    end

    // Instruction array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch mux: real content only for in-range addresses of a completed load.
    always_comb begin
        in_range   = (addr_p0[ADDR_W-1:IDX_W] == '0);
        fetch_ok   = in_range && loaded && !ld_busy;
        inst_valid = fetch_ok;
        inst       = fetch_ok ? mem[addr_p0[IDX_W-1:0]] : NOP_WORD;
    end

endmodule : isr_imem_loadable
